// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes decoded instruction fields into 16-bit words,
// buffers them in a small FIFO and writes them sequentially to program memory.
// Ports: clk/reset, start/start_addr session control, in_* field stream
// (valid/ready), mem_write_* memory port (valid/ready), status outputs
// busy/done/err_illegal/err_overflow/words_written/checksum.
// Option: define ENC_CHECKSUM_EN to build the running XOR checksum.
module instr_encoder_loader #(
  parameter int ADDR_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_opcode,
  input  logic [3:0]           in_rd,
  input  logic [3:0]           in_rs,
  input  logic [3:0]           in_rt,
  input  logic [7:0]           in_imm8,
  input  logic [3:0]           in_condition,
  output logic                 mem_write_valid,
  input  logic                 mem_write_ready,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [15:0]          mem_write_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err_illegal,
  output logic                 err_overflow,
  output logic [ADDR_BITS:0]   words_written,
  output logic [15:0]          checksum
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_BITS-1:0] TOP = '1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t               state;
  logic [15:0]          fifo [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW:0]          count;
  logic [ADDR_BITS-1:0] addr;
  logic [15:0]          enc_word;
  logic [15:0]          head;
  logic                 illegal;
  logic                 is_halt;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 ovf;
  logic                 full;
  logic                 empty;
  logic                 active;
  logic                 sess_start;

  always_comb begin
    enc_word = '0;
    illegal  = 1'b0;
    unique case (in_opcode)
      4'h0:    enc_word = 16'h0000;
      4'h1:    enc_word = {in_opcode, in_condition, in_imm8};
      4'h2,
      4'h8:    enc_word = {in_opcode, 4'h0, in_rs, in_rt};
      4'h3,
      4'h4,
      4'h5,
      4'h6:    enc_word = {in_opcode, in_rd, in_rs, in_rt};
      4'h7:    enc_word = {in_opcode, in_rd, in_rs, 4'h0};
      4'h9:    enc_word = {in_opcode, in_rd, in_imm8};
      4'hF:    enc_word = 16'hF000;
      default: illegal  = 1'b1;
    endcase
  end

  assign is_halt    = (in_opcode == 4'hF);
  assign full       = (count == (PW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign active     = (state == LOAD) || (state == DRAIN);
  assign sess_start = start && ((state == IDLE) || (state == DONE));

  // in_ready looks only at registered occupancy, so a same-cycle pop
  // never opens a slot early.
  assign in_ready = (state == LOAD) && !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && !illegal;

  assign head              = fifo[rd_ptr];
  assign mem_write_valid   = active && !empty;
  assign mem_write_data    = mem_write_valid ? head : 16'h0000;
  assign mem_write_address = addr;
  assign pop               = mem_write_valid && mem_write_ready;

  // Writing the last address with anything but HALT means the program
  // does not fit.
  assign ovf = pop && (addr == TOP) && (head != 16'hF000);

  assign busy = active;
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      addr          <= '0;
      words_written <= '0;
      err_illegal   <= 1'b0;
      err_overflow  <= 1'b0;
    end else if (sess_start) begin
      state         <= LOAD;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      addr          <= start_addr;
      words_written <= '0;
      err_illegal   <= 1'b0;
      err_overflow  <= 1'b0;
    end else if (active) begin
      if (pop) begin
        rd_ptr        <= rd_ptr + PW'(1);
        words_written <= words_written + (ADDR_BITS+1)'(1);
        if (addr != TOP) addr <= addr + ADDR_BITS'(1);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (accept && illegal) err_illegal <= 1'b1;
      if (accept && is_halt) state <= DRAIN;
      if ((state == DRAIN) && empty) state <= DONE;
      if (ovf) begin
        err_overflow <= 1'b1;
        state        <= DONE;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
      end
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [15:0] cks_q;

  always_ff @(posedge clk) begin
    if (reset) cks_q <= '0;
    else if (sess_start) cks_q <= '0;
    else if (pop) cks_q <= cks_q ^ head;
  end

  assign checksum = cks_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: randomized + directed bench for instr_encoder_loader
// against a queue-based behavioural model compared every cycle.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0;
  logic [3:0]  in_rd = '0;
  logic [3:0]  in_rs = '0;
  logic [3:0]  in_rt = '0;
  logic [7:0]  in_imm8 = '0;
  logic [3:0]  in_condition = '0;
  logic        mem_write_valid;
  logic        mem_write_ready = 1'b0;
  logic [7:0]  mem_write_address;
  logic [15:0] mem_write_data;
  logic        busy;
  logic        done;
  logic        err_illegal;
  logic        err_overflow;
  logic [8:0]  words_written;
  logic [15:0] checksum;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .start_addr(start_addr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_opcode(in_opcode),
    .in_rd(in_rd),
    .in_rs(in_rs),
    .in_rt(in_rt),
    .in_imm8(in_imm8),
    .in_condition(in_condition),
    .mem_write_valid(mem_write_valid),
    .mem_write_ready(mem_write_ready),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .busy(busy),
    .done(done),
    .err_illegal(err_illegal),
    .err_overflow(err_overflow),
    .words_written(words_written),
    .checksum(checksum)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Field placement by which operands each opcode uses.
  function automatic logic [16:0] enc(input logic [3:0] op,
                                      input logic [3:0] rd,
                                      input logic [3:0] rs,
                                      input logic [3:0] rt,
                                      input logic [3:0] c,
                                      input logic [7:0] imm);
    logic [15:0] w;
    w = {op, 12'h000};
    if (op inside {[10:14]}) return 17'h10000;
    if (op inside {[3:7], 9}) w[11:8] = rd;
    if (op == 4'd1) w[11:8] = c;
    if (op inside {[2:8]}) w[7:4] = rs;
    if (op inside {[2:6], 8}) w[3:0] = rt;
    if (op inside {1, 9}) w[7:0] = imm;
    return {1'b0, w};
  endfunction

  typedef enum {M_IDLE, M_LOAD, M_DRAIN, M_DONE} mst_t;

  mst_t        m_st = M_IDLE;
  logic [15:0] m_q[$];
  int          m_addr = 0;
  int          m_words = 0;
  bit          m_ill = 0;
  bit          m_ovf = 0;
  logic [15:0] m_cks = '0;
  bit          m_ok = 0;

  always @(posedge clk) begin : model
    int sz;
    bit hs;
    bit acc;
    bit ov;
    logic [16:0] e;
    logic [15:0] w;
    mst_t nx;
    if (reset) begin
      m_st = M_IDLE; m_q.delete(); m_addr = 0; m_words = 0;
      m_ill = 0; m_ovf = 0; m_cks = '0;
    end else if (m_st == M_IDLE || m_st == M_DONE) begin
      if (start) begin
        m_st = M_LOAD; m_q.delete(); m_addr = int'(start_addr);
        m_words = 0; m_ill = 0; m_ovf = 0; m_cks = '0;
      end
    end else begin
      sz = m_q.size();
      hs = (sz > 0) && mem_write_ready;
      acc = (m_st == M_LOAD) && in_valid && (sz < 4);
      nx = m_st;
      ov = 0;
      if (hs) begin
        w = m_q.pop_front();
        m_words++;
        m_cks ^= w;
        ov = (m_addr == 255) && (w != 16'hF000);
        if (m_addr < 255) m_addr++;
      end
      if (acc) begin
        e = enc(in_opcode, in_rd, in_rs, in_rt, in_condition, in_imm8);
        if (e[16]) m_ill = 1;
        else begin
          m_q.push_back(e[15:0]);
          if (in_opcode == 4'hF) nx = M_DRAIN;
        end
      end
      if (m_st == M_DRAIN && sz == 0) nx = M_DONE;
      if (ov) begin
        m_ovf = 1; m_q.delete(); nx = M_DONE;
      end
      m_st = nx;
    end
    m_ok = 1;
  end

  logic [23:0] wlog[$];

  always @(posedge clk) begin
    if (!reset && mem_write_valid && mem_write_ready)
      wlog.push_back({mem_write_address, mem_write_data});
  end

  always @(negedge clk) begin : compare
    bit ev;
    logic [15:0] ec;
    if (m_ok) begin
      ev = (m_st == M_LOAD || m_st == M_DRAIN) && (m_q.size() > 0);
`ifdef ENC_CHECKSUM_EN
      ec = m_cks;
`else
      ec = 16'h0000;
`endif
      chk("in_ready", in_ready, (m_st == M_LOAD) && (m_q.size() < 4));
      chk("wr_valid", mem_write_valid, ev);
      chk("wr_addr", mem_write_address, m_addr);
      if (ev) chk("wr_data", mem_write_data, m_q[0]);
      chk("busy", busy, (m_st == M_LOAD || m_st == M_DRAIN));
      chk("done", done, m_st == M_DONE);
      chk("err_illegal", err_illegal, m_ill);
      chk("err_overflow", err_overflow, m_ovf);
      chk("words", words_written, m_words);
      chk("checksum", checksum, ec);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [7:0] a);
    wlog.delete();
    start = 1'b1;
    start_addr = a;
    step(1);
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] rd,
                      input logic [3:0] rs, input logic [3:0] rt,
                      input logic [7:0] imm, input logic [3:0] c);
    bit acc;
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs = rs;
    in_rt = rt; in_imm8 = imm; in_condition = c;
    for (int n = 0; n < 200; n++) begin
      acc = in_ready;
      step(1);
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("send_timeout", 0, 1);
  endtask

  task automatic wait_done(input string nm);
    for (int n = 0; n < 300; n++) begin
      if (done) break;
      step(1);
    end
    chk(nm, done, 1);
  endtask

  task automatic chk_log(input string nm, input int i,
                         input logic [7:0] a, input logic [15:0] d);
    logic [31:0] act;
    act = (i < wlog.size()) ? {8'h00, wlog[i]} : 32'hFFFFFFFF;
    chk(nm, act, {8'h00, a, d});
  endtask

  initial begin
    int k;
    bit acc;
    logic [15:0] e3 [4];

    step(3);
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valid", mem_write_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words", words_written, 0);
    chk("rst_addr", mem_write_address, 0);

    // basic program
    mem_write_ready = 1'b1;
    do_start(8'h00);
    send(4'h9, 4'h1, 4'h0, 4'h0, 8'h2A, 4'h0);
    send(4'h3, 4'h2, 4'h1, 4'h1, 8'h00, 4'h0);
    send(4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0);
    wait_done("t1_done");
    chk("t1_n", wlog.size(), 3);
    chk_log("t1_w0", 0, 8'h00, 16'h912A);
    chk_log("t1_w1", 1, 8'h01, 16'h3211);
    chk_log("t1_w2", 2, 8'h02, 16'hF000);
    chk("t1_words", words_written, 3);
    chk("t1_busy", busy, 0);
`ifdef ENC_CHECKSUM_EN
    chk("t1_cks", checksum, 16'h533B);
`else
    chk("t1_cks", checksum, 16'h0000);
`endif

    // other formats
    do_start(8'h10);
    chk("t2_done_drop", done, 0);
    send(4'h2, 4'h0, 4'h3, 4'h4, 8'h00, 4'h0);
    send(4'h8, 4'h0, 4'h5, 4'h6, 8'h00, 4'h0);
    send(4'h1, 4'h0, 4'h0, 4'h0, 8'h10, 4'h4);
    send(4'h7, 4'h7, 4'h2, 4'h0, 8'h00, 4'h0);
    send(4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0);
    wait_done("t2_done");
    chk_log("t2_w0", 0, 8'h10, 16'h2034);
    chk_log("t2_w1", 1, 8'h11, 16'h8056);
    chk_log("t2_w2", 2, 8'h12, 16'h1410);
    chk_log("t2_w3", 3, 8'h13, 16'h7720);
    chk_log("t2_w4", 4, 8'h14, 16'hF000);

    // backpressure
    do_start(8'h20);
    mem_write_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_opcode = 4'h3; in_rd = 4'(k);
      in_rs = 4'h1; in_rt = 4'h2;
      acc = in_ready;
      step(1);
      if (acc) k++;
      if (i >= 2) begin
        chk("t3_valid", mem_write_valid, 1);
        chk("t3_addr", mem_write_address, 8'h20);
        chk("t3_data", mem_write_data, 16'h3012);
      end
    end
    in_valid = 1'b0;
    chk("t3_accepts", k, 4);
    chk("t3_in_ready", in_ready, 0);
    mem_write_ready = 1'b1;
    send(4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0);
    wait_done("t3_done");
    e3[0] = 16'h3012; e3[1] = 16'h3112; e3[2] = 16'h3212; e3[3] = 16'h3312;
    for (int i = 0; i < 4; i++)
      chk_log("t3_order", i, 8'(8'h20 + i), e3[i]);
    chk_log("t3_halt", 4, 8'h24, 16'hF000);

    // illegal opcode
    do_start(8'h30);
    send(4'h3, 4'h1, 4'h2, 4'h3, 8'h00, 4'h0);
    send(4'hB, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0);
    send(4'h3, 4'h4, 4'h5, 4'h6, 8'h00, 4'h0);
    step(4);
    chk("t4_ill", err_illegal, 1);
    chk("t4_words", words_written, 2);
    chk_log("t4_w0", 0, 8'h30, 16'h3123);
    chk_log("t4_w1", 1, 8'h31, 16'h3456);
    send(4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0);
    wait_done("t4_done");
    chk("t4_ill_held", err_illegal, 1);

    // overflow at top of memory
    do_start(8'hFE);
    send(4'h3, 4'h1, 4'h1, 4'h1, 8'h00, 4'h0);
    send(4'h3, 4'h2, 4'h2, 4'h2, 8'h00, 4'h0);
    send(4'h3, 4'h3, 4'h3, 4'h3, 8'h00, 4'h0);
    wait_done("t5_done");
    step(2);
    chk("t5_ovf", err_overflow, 1);
    chk("t5_words", words_written, 2);
    chk("t5_n", wlog.size(), 2);
    chk_log("t5_w1", 1, 8'hFF, 16'h3222);
    chk("t5_valid", mem_write_valid, 0);

    // reset mid-session
    do_start(8'h40);
    mem_write_ready = 1'b0;
    send(4'h3, 4'h1, 4'h1, 4'h1, 8'h00, 4'h0);
    send(4'h3, 4'h2, 4'h2, 4'h2, 8'h00, 4'h0);
    reset = 1'b1;
    step(1);
    chk("t6_valid", mem_write_valid, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_words", words_written, 0);
    reset = 1'b0;
    step(1);
    mem_write_ready = 1'b1;
    do_start(8'h50);
    send(4'h9, 4'h5, 4'h0, 4'h0, 8'h77, 4'h0);
    send(4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0);
    wait_done("t6_done");
    chk_log("t6_w0", 0, 8'h50, 16'h9577);
    chk("t6_words2", words_written, 2);

    // randomized sessions
    for (int s = 0; s < 12; s++) begin
      do_start((s % 3 == 0) ? 8'($urandom_range(240, 255))
                            : 8'($urandom_range(0, 255)));
      for (int c = 0; c < 150; c++) begin
        if (done) break;
        k = int'($urandom % 20);
        in_valid = 1'($urandom % 2);
        in_opcode = (k >= 16) ? 4'h3 : 4'(k);
        in_rd = 4'($urandom); in_rs = 4'($urandom);
        in_rt = 4'($urandom); in_imm8 = 8'($urandom);
        in_condition = 4'($urandom);
        mem_write_ready = ($urandom % 4) != 0;
        start = ($urandom % 25) == 0;
        start_addr = 8'($urandom);
        step(1);
        start = 1'b0;
      end
      mem_write_ready = 1'b1;
      for (int c = 0; c < 100; c++) begin
        if (done) break;
        in_valid = in_ready;
        in_opcode = 4'hF;
        step(1);
      end
      in_valid = 1'b0;
      wait_done("rand_done");
    end

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
